// File: rtl/decode_pkg.sv
// Shared decode-stage constants: immediate formats, control bundle layout, reset values.
// Optional W->D write bypass is enabled by defining DECODE_WB_BYPASS_EN.
package decode_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam int CTRL_WIDTH    = 10;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_JUMP     = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_RESSRC   = 5;
    localparam int CTRL_ALUCTRL  = 7;

    localparam logic RST_VALID = 1'b0;

endpackage

// File: rtl/decode_stage_pipe_regfile.sv
// 2R1W register file with hard-wired x0 and optional write-first bypass.
// Bypass is compiled in when DECODE_WB_BYPASS_EN is defined.
module regfile_2r1w
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] mem [NREG];
    logic            wr_hit;

    assign wr_hit = we && (wa != '0) && (int'(wa) < NREG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wr_hit) begin
            mem[wa] <= wd;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        read_port = '0;
        if (a != '0 && int'(a) < NREG) begin
            read_port = mem[a];
`ifdef DECODE_WB_BYPASS_EN
            if (wr_hit && wa == a) read_port = wd;
`endif
        end
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file read, immediate generation and the D->E register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = CTRL_WIDTH,
    localparam int AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [31:0]       instr_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pcplus4_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [2:0]        imm_src_d,
    input  logic              stall_d,
    input  logic              flush_e,
    input  logic              we_w,
    input  logic [AW-1:0]     rd_w,
    input  logic [XLEN-1:0]   result_w,
    output logic              valid_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [AW-1:0]     rs1_e,
    output logic [AW-1:0]     rs2_e,
    output logic [AW-1:0]     rd_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pcplus4_e
);

    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [AW-1:0]   rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
    logic [31:0]     imm32;
    logic            unused_opcode;

    assign rs1_f = instr_d[19:15];
    assign rs2_f = instr_d[24:20];
    assign rd_f  = instr_d[11:7];
    assign rs1_d = rs1_f[AW-1:0];
    assign rs2_d = rs2_f[AW-1:0];
    assign rd_d  = rd_f[AW-1:0];
    assign unused_opcode = ^instr_d[6:0];

    regfile_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_d),
        .ra2 (rs2_d),
        .we  (we_w),
        .wa  (rd_w),
        .wd  (result_w),
        .rd1 (rd1_d),
        .rd2 (rd2_d)
    );

    always_comb begin
        imm32 = '0;
        unique case (imm_src_d)
            IMM_I: imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
            IMM_S: imm32 = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            IMM_B: imm32 = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25],
                            instr_d[11:8], 1'b0};
            IMM_J: imm32 = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20],
                            instr_d[30:21], 1'b0};
            IMM_U: imm32 = {instr_d[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // All formats are 32-bit signed; widen to XLEN by sign extension.
    assign imm_d = XLEN'($signed(imm32));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_e   <= RST_VALID;
            ctrl_e    <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            imm_e     <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
            pc_e      <= '0;
            pcplus4_e <= '0;
        end else if (flush_e) begin
            valid_e   <= 1'b0;
            ctrl_e    <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            imm_e     <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
            pc_e      <= '0;
            pcplus4_e <= '0;
        end else if (!stall_d) begin
            valid_e   <= valid_d;
            ctrl_e    <= valid_d ? ctrl_d : '0;
            rd1_e     <= rd1_d;
            rd2_e     <= rd2_d;
            imm_e     <= imm_d;
            rs1_e     <= rs1_d;
            rs2_e     <= rs2_d;
            rd_e      <= rd_d;
            pc_e      <= pc_d;
            pcplus4_e <= pcplus4_d;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomized self-checking bench for decode_stage_pipe against a behavioural model.
// Honours DECODE_WB_BYPASS_EN in the model when the design is built with it.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_d = 1'b0;
    logic [31:0] instr_d = '0;
    logic [31:0] pc_d = '0;
    logic [31:0] pcplus4_d = '0;
    logic [9:0]  ctrl_d = '0;
    logic [2:0]  imm_src_d = '0;
    logic        stall_d = 1'b0;
    logic        flush_e = 1'b0;
    logic        we_w = 1'b0;
    logic [4:0]  rd_w = '0;
    logic [31:0] result_w = '0;
    logic        valid_e;
    logic [9:0]  ctrl_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pcplus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];
    logic        m_valid;
    logic [9:0]  m_ctrl;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
    logic [4:0]  m_rs1, m_rs2, m_rd;

    decode_stage_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .valid_d   (valid_d),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pcplus4_d (pcplus4_d),
        .ctrl_d    (ctrl_d),
        .imm_src_d (imm_src_d),
        .stall_d   (stall_d),
        .flush_e   (flush_e),
        .we_w      (we_w),
        .rd_w      (rd_w),
        .result_w  (result_w),
        .valid_e   (valid_e),
        .ctrl_e    (ctrl_e),
        .rd1_e     (rd1_e),
        .rd2_e     (rd2_e),
        .imm_e     (imm_e),
        .rs1_e     (rs1_e),
        .rs2_e     (rs2_e),
        .rd_e      (rd_e),
        .pc_e      (pc_e),
        .pcplus4_e (pcplus4_e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] imm_ref(input logic [31:0] i,
                                            input logic [2:0] src);
        logic signed [31:0] s;
        s = $signed(i);
        case (src)
            3'd0: return 32'(s >>> 20);
            3'd1: return 32'((s >>> 25) <<< 5) | 32'(i[11:7]);
            3'd2: return ((s[31] ? 32'hFFFF_F000 : 32'h0)
                          | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
                          | (32'(i[11:8]) << 1));
            3'd3: return ((s[31] ? 32'hFFF0_0000 : 32'h0)
                          | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
                          | (32'(i[30:21]) << 1));
            3'd4: return i & 32'hFFFF_F000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rf_ref(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
        if (we_w && rd_w != 0 && rd_w == a) return result_w;
`endif
        return rf[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) rf[i] = '0;
        {m_valid, m_ctrl, m_rd1, m_rd2, m_imm} = '0;
        {m_pc, m_pc4, m_rs1, m_rs2, m_rd} = '0;
    endtask

    task automatic check_e(input string tag);
        chk({tag, ".valid"}, 64'(valid_e), 64'(m_valid));
        chk({tag, ".ctrl"}, 64'(ctrl_e), 64'(m_ctrl));
        chk({tag, ".rd1"}, 64'(rd1_e), 64'(m_rd1));
        chk({tag, ".rd2"}, 64'(rd2_e), 64'(m_rd2));
        chk({tag, ".imm"}, 64'(imm_e), 64'(m_imm));
        chk({tag, ".rs1"}, 64'(rs1_e), 64'(m_rs1));
        chk({tag, ".rs2"}, 64'(rs2_e), 64'(m_rs2));
        chk({tag, ".rd"}, 64'(rd_e), 64'(m_rd));
        chk({tag, ".pc"}, 64'(pc_e), 64'(m_pc));
        chk({tag, ".pc4"}, 64'(pcplus4_e), 64'(m_pc4));
    endtask

    // Advance one edge: predict E and the register file, then compare.
    task automatic tick(input string tag);
        if (flush_e) begin
            {m_valid, m_ctrl, m_rd1, m_rd2, m_imm} = '0;
            {m_pc, m_pc4, m_rs1, m_rs2, m_rd} = '0;
        end else if (!stall_d) begin
            m_valid = valid_d;
            m_ctrl  = valid_d ? ctrl_d : 10'h0;
            m_rd1   = rf_ref(instr_d[19:15]);
            m_rd2   = rf_ref(instr_d[24:20]);
            m_imm   = imm_ref(instr_d, imm_src_d);
            m_rs1   = instr_d[19:15];
            m_rs2   = instr_d[24:20];
            m_rd    = instr_d[11:7];
            m_pc    = pc_d;
            m_pc4   = pcplus4_d;
        end
        if (we_w && rd_w != 0) rf[rd_w] = result_w;
        @(posedge clk);
        #1;
        check_e(tag);
    endtask

    task automatic set_d(input logic v, input logic [31:0] ins,
                         input logic [2:0] src, input logic [9:0] c);
        valid_d   = v;
        instr_d   = ins;
        imm_src_d = src;
        ctrl_d    = c;
        pc_d      = $urandom;
        pcplus4_d = pc_d + 32'd4;
    endtask

    task automatic set_w(input logic we, input logic [4:0] rd,
                         input logic [31:0] res);
        we_w = we;
        rd_w = rd;
        result_w = res;
    endtask

    initial begin
        clear_model();
        #12;
        chk("reset.valid", 64'(valid_e), 64'h0);
        chk("reset.rd1", 64'(rd1_e), 64'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Write x5 then read it; x0 write must be ignored.
        set_w(1'b1, 5'd5, 32'hDEAD_BEEF);
        set_d(1'b1, 32'h0000_0013, 3'd0, 10'h001);
        tick("wr5");
        set_w(1'b1, 5'd0, 32'h0000_1234);
        set_d(1'b1, 32'h0000_0000 | (32'd5 << 15), 3'd0, 10'h001);
        tick("rd5");
        chk("x5_read", 64'(rd1_e), 64'hDEAD_BEEF);
        set_w(1'b0, 5'd0, 32'h0);
        set_d(1'b1, 32'h0000_0000, 3'd0, 10'h001);
        tick("rd0");
        chk("x0_read", 64'(rd1_e), 64'h0);

        // Same-cycle writeback to a register being read.
        set_w(1'b1, 5'd7, 32'h0000_0011);
        tick("wr7");
        set_w(1'b1, 5'd7, 32'hA5A5_A5A5);
        set_d(1'b1, 32'd7 << 15, 3'd0, 10'h002);
        tick("byp7");
`ifdef DECODE_WB_BYPASS_EN
        chk("wd_bypass", 64'(rd1_e), 64'hA5A5_A5A5);
`else
        chk("wd_nobypass", 64'(rd1_e), 64'h0000_0011);
`endif
        set_w(1'b0, 5'd0, 32'h0);

        // Stall then stall+flush on an ADDI.
        set_d(1'b1, 32'h0050_0093, 3'd0, 10'h3FF);
        tick("addi");
        stall_d = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_d(1'b1, $urandom, 3'($urandom_range(0, 4)), 10'($urandom));
            tick("stall");
        end
        chk("stall_ctrl", 64'(ctrl_e), 64'h3FF);
        flush_e = 1'b1;
        tick("flush");
        chk("flush_valid", 64'(valid_e), 64'h0);
        flush_e = 1'b0;
        stall_d = 1'b0;

        // Immediate corner cases.
        set_d(1'b1, 32'hFFF0_0093, 3'd0, 10'h1);
        tick("immI");
        chk("immI_val", 64'(imm_e), 64'hFFFF_FFFF);
        set_d(1'b1, 32'h1234_50B7, 3'd4, 10'h1);
        tick("immU");
        chk("immU_val", 64'(imm_e), 64'h1234_5000);
        set_d(1'b1, 32'h0080_006F, 3'd3, 10'h1);
        tick("immJ");
        chk("immJ_val", 64'(imm_e), 64'h8);
        set_d(1'b1, 32'hFFFF_FFFF, 3'd7, 10'h1);
        tick("imm7");
        chk("imm7_val", 64'(imm_e), 64'h0);

        // Bubble with a non-zero control bundle.
        set_d(1'b0, 32'h0050_0093, 3'd0, 10'h3FF);
        tick("bubble");
        chk("bubble_ctrl", 64'(ctrl_e), 64'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            set_d(1'($urandom), $urandom, 3'($urandom_range(0, 7)),
                  10'($urandom));
            stall_d = ($urandom_range(0, 5) == 0);
            flush_e = ($urandom_range(0, 7) == 0);
            set_w(1'($urandom), 5'($urandom), $urandom);
            tick("rand");
        end
        stall_d = 1'b0;
        flush_e = 1'b0;

        // Reset mid-cycle with a pending write to x5.
        set_w(1'b1, 5'd5, 32'hCAFE_F00D);
        #2;
        rst = 1'b0;
        #1;
        clear_model();
        check_e("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_w(1'b0, 5'd0, 32'h0);
        set_d(1'b1, 32'd5 << 15, 3'd0, 10'h1);
        tick("post_rst");
        chk("x5_after_rst", 64'(rd1_e), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
